// File: rtl/dec_sync.sv
// Code-hold decoder: accepts a 2-bit priority-encoder index, holds its one-hot
// decode for HOLD cycles, then a single GAP cycle with a done pulse.
module dec_sync #(
  parameter int HOLD = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] in,
  input  logic       valid,
  output logic [3:0] out,
  output logic       busy,
  output logic       done,
  output logic       ovr
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(HOLD - 1);

  state_t     r_state, w_state_nxt;
  logic [3:0] r_cnt,   w_cnt_nxt;
  logic [1:0] r_code,  w_code_nxt;
  logic [3:0] r_out,   w_out_nxt;
  logic       r_busy,  w_busy_nxt;
  logic       r_done,  w_done_nxt;
  logic       r_ovr,   w_ovr_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_code  <= 2'd0;
      r_out   <= 4'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_code  <= w_code_nxt;
      r_out   <= w_out_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_ovr   <= w_ovr_nxt;
    end
  end

  // The edge leaving GAP may accept a new code, giving back-to-back
  // acceptances a period of HOLD+1 cycles.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_code_nxt  = r_code;
    w_out_nxt   = r_out;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_ovr_nxt   = r_ovr;
    case (r_state)
      S_IDLE, S_GAP: begin
        if (valid) begin
          w_state_nxt = S_HOLD;
          w_code_nxt  = in;
          w_cnt_nxt   = CNT_LOAD;
          w_out_nxt   = 4'b0001 << in;
          w_busy_nxt  = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
          w_out_nxt   = 4'd0;
          w_busy_nxt  = 1'b0;
        end
      end
      S_HOLD: begin
        if (valid) begin
          w_ovr_nxt = 1'b1;
        end
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_GAP;
          w_out_nxt   = 4'd0;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
          w_out_nxt = 4'b0001 << r_code;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
        w_out_nxt   = 4'd0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign out  = r_out;
  assign busy = r_busy;
  assign done = r_done;
  assign ovr  = r_ovr;

endmodule
